// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store alignment unit: access-size
// encodings, FSM state type and small helpers for byte counts and
// load-data extension.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SECOND = 1'b1
    } lsu_state_e;

    // Number of bytes touched by an access of the given size (1, 2 or 4).
    function automatic logic [2:0] nbytes(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            SZ_BYTE: n = 3'd1;
            SZ_HALF: n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    // Sign- or zero-extend right-aligned load data to 32 bits.
    function automatic logic [31:0] extend(input logic [31:0] d,
                                           input logic [1:0]  size,
                                           input logic        uns);
        logic [31:0] r;
        case (size)
            SZ_BYTE: r = {{24{d[7] & ~uns}}, d[7:0]};
            SZ_HALF: r = {{16{d[15] & ~uns}}, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_lane_merge.sv
// Byte-lane merge for stores: lanes offset_i .. offset_i+count_i-1 of the
// old word are replaced by consecutive bytes of data_i starting at byte
// start_i. Lanes outside that window keep their old value.
module lsu_lane_merge (
    input  logic [31:0] old_i,
    input  logic [31:0] data_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  count_i,
    input  logic [1:0]  start_i,
    output logic [31:0] merged_o
);

    logic [3:0][7:0] data_b;
    assign data_b = data_i;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic       in_range;
        logic [1:0] src;
        // Lane is written when it falls inside [offset, offset+count).
        assign in_range = (3'(gi) >= {1'b0, offset_i}) &&
                          (3'(gi) < ({1'b0, offset_i} + count_i));
        // Source byte index; modulo-4 arithmetic is exact inside the window.
        assign src = start_i + 2'(gi) - offset_i;
        assign merged_o[8*gi +: 8] = in_range ? data_b[src] : old_i[8*gi +: 8];
    end

endmodule

// File: rtl/lsu_align.sv
// MEM-stage load/store alignment unit. Converts byte-addressed requests
// into word accesses on a word-indexed data memory, merging store bytes
// and extracting/extending load bytes. Accesses that cross a word
// boundary take two memory cycles with a one-cycle stall.
// Build option: define LSU_MISALIGN_TRAP_EN to trap crossing accesses
// (no memory access, misalign_trap pulse) instead of splitting them.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DMEM_ADDR_WIDTH = 10,
    parameter int DMEM_DEPTH      = 2**DMEM_ADDR_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset_b,
    input  logic                       req_valid,
    input  logic [31:0]                req_addr,
    input  logic [31:0]                req_wdata,
    input  logic                       req_read,
    input  logic                       req_write,
    input  logic [1:0]                 req_size,
    input  logic                       req_unsigned,
    output logic                       stall,
    output logic                       rsp_valid,
    output logic [31:0]                rsp_rdata,
    output logic                       misalign_trap,
    output logic [DMEM_ADDR_WIDTH-1:0] dm_addr,
    output logic [31:0]                dm_din,
    output logic                       dm_mem_read,
    output logic                       dm_mem_write,
    output logic [1:0]                 dm_size,
    output logic                       dm_notsigned,
    input  logic [31:0]                dm_dout
);

    lsu_state_e                 state_q, state_d;
    logic                       store_q;
    logic [1:0]                 size_q;
    logic                       uns_q;
    logic [1:0]                 off_q;
    logic [DMEM_ADDR_WIDTH-1:0] waddr_q;
    logic [31:0]                wdata_q;
    logic [31:0]                ld_lo_q;
    logic                       rsp_valid_q;
    logic [31:0]                rsp_rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
    logic                       trap_q;
`endif

    logic                       is_store, is_load, active, crossing;
    logic [1:0]                 off;
    logic [2:0]                 nb;
    logic [DMEM_ADDR_WIDTH-1:0] w, w_next;
    logic [1:0]                 lo_bytes_q;
    logic [31:0]                ld_shift, ld_comb;
    logic [31:0]                mg_data, merged;
    logic [1:0]                 mg_off, mg_start;
    logic [2:0]                 mg_count;
    logic                       unused_addr;

    // Request decode; a store wins when read and write are both asserted.
    assign is_store = req_valid & req_write;
    assign is_load  = req_valid & req_read & ~req_write;
    assign active   = is_store | is_load;
    assign off      = req_addr[1:0];
    assign w        = req_addr[DMEM_ADDR_WIDTH+1:2];
    assign w_next   = (w == DMEM_ADDR_WIDTH'(DMEM_DEPTH - 1)) ? '0 : w + 1'b1;
    assign nb       = nbytes(req_size);
    assign crossing = ({1'b0, off} + nb) > 3'd4;
    assign unused_addr = ^req_addr[31:DMEM_ADDR_WIDTH+2];

    // Bytes of the access that landed in the first word (4 - off, off >= 1).
    assign lo_bytes_q = 2'd0 - off_q;
    assign ld_shift   = dm_dout >> {off, 3'b000};
    assign ld_comb    = ld_lo_q | (dm_dout << {lo_bytes_q, 3'b000});

    // Merge window: first (or only) half in IDLE, remainder in SECOND.
    always_comb begin
        mg_data  = req_wdata;
        mg_off   = off;
        mg_start = 2'd0;
        mg_count = crossing ? (3'd4 - {1'b0, off}) : nb;
        if (state_q == ST_SECOND) begin
            mg_data  = wdata_q;
            mg_off   = 2'd0;
            mg_start = lo_bytes_q;
            mg_count = nbytes(size_q) - {1'b0, lo_bytes_q};
        end
    end

    lsu_lane_merge u_merge (
        .old_i    (dm_dout),
        .data_i   (mg_data),
        .offset_i (mg_off),
        .count_i  (mg_count),
        .start_i  (mg_start),
        .merged_o (merged)
    );

    // Memory-side control and next state.
    always_comb begin
        state_d      = state_q;
        dm_addr      = '0;
        dm_mem_read  = 1'b0;
        dm_mem_write = 1'b0;
        stall        = 1'b0;
        case (state_q)
            ST_IDLE: begin
`ifdef LSU_MISALIGN_TRAP_EN
                if (active && !crossing) begin
                    dm_addr      = w;
                    dm_mem_read  = 1'b1;
                    dm_mem_write = is_store;
                end
`else
                if (active) begin
                    dm_addr      = w;
                    dm_mem_read  = 1'b1;
                    dm_mem_write = is_store;
                    stall        = crossing;
                    if (crossing) state_d = ST_SECOND;
                end
`endif
            end
            ST_SECOND: begin
                dm_addr      = waddr_q;
                dm_mem_read  = 1'b1;
                dm_mem_write = store_q;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign dm_din       = merged;
    assign dm_size      = SZ_WORD;
    assign dm_notsigned = 1'b0;

    // FSM state, captured split-access info and registered load response.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q     <= ST_IDLE;
            store_q     <= 1'b0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            off_q       <= 2'b00;
            waddr_q     <= '0;
            wdata_q     <= '0;
            ld_lo_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            trap_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            trap_q      <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (active && crossing) begin
`ifdef LSU_MISALIGN_TRAP_EN
                        trap_q <= 1'b1;
                        if (is_load) begin
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= '0;
                        end
`else
                        store_q <= is_store;
                        size_q  <= req_size;
                        uns_q   <= req_unsigned;
                        off_q   <= off;
                        waddr_q <= w_next;
                        wdata_q <= req_wdata;
                        ld_lo_q <= ld_shift;
`endif
                    end else if (is_load) begin
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= extend(ld_shift, req_size, req_unsigned);
                    end
                end
                ST_SECOND: begin
                    if (!store_q) begin
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= extend(ld_comb, size_q, uns_q);
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign_trap = trap_q;
`else
    assign misalign_trap = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_align.sv
// Directed bench for lsu_align with a behavioural data memory model.
module tb_lsu_align;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset_b;
    logic        req_valid, req_read, req_write, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        stall, rsp_valid, misalign_trap;
    logic [31:0] rsp_rdata;
    logic [9:0]  dm_addr;
    logic [31:0] dm_din, dm_dout;
    logic        dm_mem_read, dm_mem_write, dm_notsigned;
    logic [1:0]  dm_size;

    logic [31:0] mem [0:1023];
    int total = 0;
    int bad   = 0;

    lsu_align dut (
        .clk           (clk),
        .reset_b       (reset_b),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_read      (req_read),
        .req_write     (req_write),
        .req_size      (req_size),
        .req_unsigned  (req_unsigned),
        .stall         (stall),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .misalign_trap (misalign_trap),
        .dm_addr       (dm_addr),
        .dm_din        (dm_din),
        .dm_mem_read   (dm_mem_read),
        .dm_mem_write  (dm_mem_write),
        .dm_size       (dm_size),
        .dm_notsigned  (dm_notsigned),
        .dm_dout       (dm_dout)
    );

    always #5 clk = ~clk;

    assign dm_dout = mem[dm_addr];
    always @(posedge clk) if (dm_mem_write) mem[dm_addr] <= dm_din;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic rd,
                         input logic wr, input logic [1:0] sz, input logic uns);
        req_valid = 1'b1; req_addr = a; req_wdata = d;
        req_read = rd; req_write = wr; req_size = sz; req_unsigned = uns;
        $display("txn addr=%08h wdata=%08h rd=%0d wr=%0d size=%0d uns=%0d", a, d, rd, wr, sz, uns);
    endtask

    task automatic idle();
        req_valid = 1'b0; req_addr = '0; req_wdata = '0;
        req_read = 1'b0; req_write = 1'b0; req_size = SZ_BYTE; req_unsigned = 1'b0;
    endtask

    initial begin
        reset_b = 1'b0;
        idle();
        mem[0] = 32'h44332211; mem[1] = 32'h88776655; mem[1023] = 32'h80000000;
        repeat (2) @(negedge clk);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_trap", {31'b0, misalign_trap}, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'h0);
        reset_b = 1'b1;
        @(negedge clk);
        chk("idle_rd", {31'b0, dm_mem_read}, 32'h0);
        chk("idle_wr", {31'b0, dm_mem_write}, 32'h0);
        chk("dm_size", {30'b0, dm_size}, 32'h2);
        chk("dm_notsigned", {31'b0, dm_notsigned}, 32'h0);

        // lb / lbu @0x7
        @(negedge clk); issue(32'h7, 32'h0, 1'b1, 1'b0, SZ_BYTE, 1'b0); #1;
        chk("lb_stall", {31'b0, stall}, 32'h0);
        chk("lb_addr", {22'b0, dm_addr}, 32'h1);
        chk("lb_rd", {31'b0, dm_mem_read}, 32'h1);
        chk("lb_wr", {31'b0, dm_mem_write}, 32'h0);
        @(negedge clk);
        chk("lb_valid", {31'b0, rsp_valid}, 32'h1);
        chk("lb_data", rsp_rdata, 32'hFFFFFF88);
        issue(32'h7, 32'h0, 1'b1, 1'b0, SZ_BYTE, 1'b1); #1;
        chk("lbu_stall", {31'b0, stall}, 32'h0);
        @(negedge clk);
        chk("lbu_valid", {31'b0, rsp_valid}, 32'h1);
        chk("lbu_data", rsp_rdata, 32'h00000088);
        idle();
        @(negedge clk);
        chk("lbu_pulse", {31'b0, rsp_valid}, 32'h0);
        chk("lbu_hold", rsp_rdata, 32'h00000088);

        // sh 0xBEEF @0x1
        @(negedge clk); issue(32'h1, 32'h0000BEEF, 1'b0, 1'b1, SZ_HALF, 1'b0); #1;
        chk("sh_stall", {31'b0, stall}, 32'h0);
        chk("sh_wr", {31'b0, dm_mem_write}, 32'h1);
        chk("sh_addr", {22'b0, dm_addr}, 32'h0);
        chk("sh_din", dm_din, 32'h44BEEF11);
        @(negedge clk); idle();
        chk("sh_w0", mem[0], 32'h44BEEF11);
        chk("sh_w1", mem[1], 32'h88776655);
        chk("sh_novalid", {31'b0, rsp_valid}, 32'h0);
        mem[0] = 32'h44332211;

        // lw @0x2 (crossing); junk store during SECOND must be ignored
        @(negedge clk); issue(32'h2, 32'h0, 1'b1, 1'b0, SZ_WORD, 1'b0); #1;
        chk("lw_stall1", {31'b0, stall}, 32'h1);
        chk("lw_addr1", {22'b0, dm_addr}, 32'h0);
        chk("lw_rd1", {31'b0, dm_mem_read}, 32'h1);
        @(negedge clk); issue(32'h0, 32'hDEADBEEF, 1'b0, 1'b1, SZ_WORD, 1'b0); #1;
        chk("lw_stall2", {31'b0, stall}, 32'h0);
        chk("lw_addr2", {22'b0, dm_addr}, 32'h1);
        chk("lw_wr2", {31'b0, dm_mem_write}, 32'h0);
        chk("lw_early", {31'b0, rsp_valid}, 32'h0);
        @(negedge clk); idle();
        chk("lw_valid", {31'b0, rsp_valid}, 32'h1);
        chk("lw_data", rsp_rdata, 32'h66554433);
        chk("lw_ignored", mem[0], 32'h44332211);
        @(negedge clk);
        chk("lw_pulse", {31'b0, rsp_valid}, 32'h0);

        // sw 0xAABBCCDD @0x3 (crossing)
        @(negedge clk); issue(32'h3, 32'hAABBCCDD, 1'b0, 1'b1, SZ_WORD, 1'b0); #1;
        chk("sw_stall1", {31'b0, stall}, 32'h1);
        chk("sw_addr1", {22'b0, dm_addr}, 32'h0);
        chk("sw_din1", dm_din, 32'hDD332211);
        @(negedge clk); idle(); #1;
        chk("sw_stall2", {31'b0, stall}, 32'h0);
        chk("sw_addr2", {22'b0, dm_addr}, 32'h1);
        chk("sw_din2", dm_din, 32'h88AABBCC);
        chk("sw_wr2", {31'b0, dm_mem_write}, 32'h1);
        @(negedge clk);
        chk("sw_w0", mem[0], 32'hDD332211);
        chk("sw_w1", mem[1], 32'h88AABBCC);
        chk("sw_novalid", {31'b0, rsp_valid}, 32'h0);

        // read+write together: store wins, no response
        @(negedge clk); issue(32'h5, 32'h0000005A, 1'b1, 1'b1, SZ_BYTE, 1'b0); #1;
        chk("rw_wr", {31'b0, dm_mem_write}, 32'h1);
        @(negedge clk); idle();
        chk("rw_w1", mem[1], 32'h88AA5ACC);
        chk("rw_novalid", {31'b0, rsp_valid}, 32'h0);

        // lh @0xFFF wraps from last word to word 0
        mem[0] = 32'h44332211; mem[1] = 32'h88776655;
        @(negedge clk); issue(32'hFFF, 32'h0, 1'b1, 1'b0, SZ_HALF, 1'b0); #1;
`ifdef LSU_MISALIGN_TRAP_EN
        chk("wrap_stall", {31'b0, stall}, 32'h0);
        chk("wrap_rd", {31'b0, dm_mem_read}, 32'h0);
        @(negedge clk); idle();
        chk("wrap_trap", {31'b0, misalign_trap}, 32'h1);
        chk("wrap_valid", {31'b0, rsp_valid}, 32'h1);
        chk("wrap_data", rsp_rdata, 32'h0);
        @(negedge clk);
        chk("wrap_trap_pulse", {31'b0, misalign_trap}, 32'h0);
`else
        chk("wrap_stall1", {31'b0, stall}, 32'h1);
        chk("wrap_addr1", {22'b0, dm_addr}, 32'd1023);
        @(negedge clk); idle(); #1;
        chk("wrap_stall2", {31'b0, stall}, 32'h0);
        chk("wrap_addr2", {22'b0, dm_addr}, 32'h0);
        @(negedge clk);
        chk("wrap_valid", {31'b0, rsp_valid}, 32'h1);
        chk("wrap_data", rsp_rdata, 32'h00001180);
        chk("wrap_trap", {31'b0, misalign_trap}, 32'h0);

        // reset asserted while in SECOND of a split store
        @(negedge clk); issue(32'h3, 32'hAABBCCDD, 1'b0, 1'b1, SZ_WORD, 1'b0);
        @(negedge clk); idle(); #1;
        reset_b = 1'b0; #1;
        chk("rst2_stall", {31'b0, stall}, 32'h0);
        chk("rst2_wr", {31'b0, dm_mem_write}, 32'h0);
        chk("rst2_valid", {31'b0, rsp_valid}, 32'h0);
        @(negedge clk); reset_b = 1'b1;
        chk("rst2_w0", mem[0], 32'hDD332211);
        chk("rst2_w1", mem[1], 32'h88776655);
`endif

        // aligned word load afterwards
        @(negedge clk); issue(32'h4, 32'h0, 1'b1, 1'b0, SZ_WORD, 1'b0); #1;
        chk("lw4_stall", {31'b0, stall}, 32'h0);
        @(negedge clk); idle();
        chk("lw4_valid", {31'b0, rsp_valid}, 32'h1);
        chk("lw4_data", rsp_rdata, 32'h88776655);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_align.md
Name: lsu_align

Overview:
- Load/store unit in the MEM stage, directly upstream of the data memory.
- Takes byte-addressed requests from the EX/MEM register and converts them into full-word accesses on the word-indexed data memory.
- Does byte-lane merge (read-modify-write) for stores and extraction/sign-extension for loads.
- Splits word-boundary-crossing accesses into two memory cycles, stalling the pipeline for one cycle; load results are registered (MEM/WB load data).

Parameters:
DMEM_DEPTH, 1024, data memory entries (32-bit words)
DMEM_ADDR_WIDTH, 10, word-index width; DMEM_DEPTH = 2**DMEM_ADDR_WIDTH

Ports:
clk  input  1  clock
reset_b  input  1  asynchronous active-low reset
req_valid  input  1  memory request present this cycle
req_addr  input  32  byte address; only bits [DMEM_ADDR_WIDTH+1:0] used
req_wdata  input  32  store data, right-aligned
req_read  input  1  load
req_write  input  1  store
req_size  input  2  00 byte, 01 half, 10/11 word
req_unsigned  input  1  zero-extend loads
stall  output  1  hold the pipeline (combinational)
rsp_valid  output  1  registered load-complete pulse
rsp_rdata  output  32  registered, extended load data
misalign_trap  output  1  registered trap pulse (optional feature; tied 0 otherwise)
dm_addr  output  DMEM_ADDR_WIDTH  word index to dmem
dm_din  output  32  merged write word
dm_mem_read  output  1  dmem read enable
dm_mem_write  output  1  dmem write enable
dm_size  output  2  constant 2'b10
dm_notsigned  output  1  constant 0
dm_dout  input  32  combinational dmem read word

Behaviour:
- Reset (async, reset_b=0): state IDLE; rsp_valid=0; rsp_rdata=0; misalign_trap=0; captured registers 0.
- Reset exit: dm_mem_read/dm_mem_write=0 until next request.
- Little-endian addressing:
  - off = req_addr[1:0]; w = req_addr[DMEM_ADDR_WIDTH+1:2].
  - nbytes is 1, 2 or 4.
  - Crossing = off+nbytes > 4.
- Store takes priority when req_read and req_write are both high; no response is generated.
- FSM states: IDLE, SECOND.
- IDLE with no request (req_valid=0 or neither read nor write): dm_mem_read=0, dm_mem_write=0, dm_addr=0, stall=0.
- IDLE, non-crossing access: one cycle, stall=0, dm_addr=w.
  - Store: dm_mem_read=1, dm_mem_write=1. dm_din = dm_dout with bytes off..off+nbytes-1 replaced by req_wdata low bytes. Written at this edge.
  - Load: dm_mem_read=1. At the edge, rsp_rdata = selected bytes, sign/zero-extended per req_unsigned; rsp_valid=1 for one cycle.
- IDLE, crossing access: stall=1 this cycle; go to SECOND.
  - Capture access info: kind, size, unsigned, off, w+1 mod DMEM_DEPTH, wdata.
  - Store: merge bytes off..3 into word w and write it.
  - Load: capture bytes off..3 of dm_dout.
- SECOND: stall=0; dm_addr = captured w+1 (wraps DMEM_DEPTH-1 -> 0); ignore req_* inputs; return to IDLE.
  - Store: merge the remaining nbytes-(4-off) bytes into bytes 0.. of word w+1 and write it.
  - Load: concatenate captured low bytes with low bytes of dm_dout; extend; register; rsp_valid=1.
- rsp_valid is a single-cycle pulse; rsp_rdata holds its value until the next load completes.
- Reset during SECOND: the first-half write is already committed; the second half is abandoned; no rsp_valid.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined:
  - Crossing accesses are not split and no dmem access occurs; stall=0.
  - misalign_trap pulses 1 at the next edge.
  - Crossing loads also pulse rsp_valid with rsp_rdata=0.
  - SECOND state is unreachable.
- Undefined: splitting as above; misalign_trap tied 0.

Decomposition:
- Shared package lsu_pkg:
  - size encoding constants SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - FSM state enum.
  - Function nbytes(size).
- One sub-module lsu_lane_merge (combinational): old word, data, offset, byte count, start byte -> merged word. Used for both store halves.

Test Plan:
- Preload word0=0x44332211, word1=0x88776655.
- lb/lbu @0x7 -> rsp_rdata 0xFFFFFF88 / 0x00000088; rsp_valid one cycle later; stall never 1.
- sh 0x0000BEEF @0x1 -> word0=0x44BEEF11 after one edge; stall 0; word1 unchanged.
- lw @0x2 -> stall=1 for exactly one cycle; dm_addr 0 then 1; rsp_rdata=0x66554433.
- sw 0xAABBCCDD @0x3 -> word0=0xDD332211, word1=0x88AABBCC; stall one cycle.
- Wrap: last word=0x80000000, lh @0xFFF -> dm_addr 1023 then 0; rsp_rdata=0x00001180. With LSU_MISALIGN_TRAP_EN: misalign_trap=1, rsp_rdata=0, no stall.
- sw 0xAABBCCDD @0x3 with reset_b low during SECOND -> word0=0xDD332211, word1 unchanged 0x88776655; rsp_valid/stall 0 after reset.
